traffic_sensor_conditioner: RTL and testbench

- Front-end stage feeding the traffic-light controller FSM.
- Synchronises and debounces the two raw street sensors.
- Generates the controller's 5 s step as a one-cycle clock-enable TICK in the CLK_100M domain, replacing a derived clock.
- Presents sensor levels that are captured and held per tick window, so a car seen at any time during a window is reported at the next TICK.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/sensor_debounce.sv | 81 ++++++++
 rtl/traffic_sensor_conditioner.sv | 72 +++++++
 tb/tb_traffic_sensor_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic sensor front end.
package traffic_pkg;

    // Per-sensor debounce states; the level is high in STABLE_HI and PEND_LO.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_e;

    // 5 s controller step and 10 ms debounce at 100 MHz.
    localparam int unsigned TICK_CYCLES_5S = 32'd500000000;
    localparam int unsigned DEBOUNCE_10MS  = 32'd1000000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debounce FSM for one raw street sensor.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int          CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    // The first differing sample loads dcnt with 1, so the level flips on the
    // edge that sees the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             deb_q, deb_d;

    // Bring the asynchronous raw input into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Next-state logic: wait for a run of differing samples, abandon on bounce.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        deb_d   = deb_q;
        case (state_q)
            STABLE_LO, STABLE_HI: begin
                if (s2_q != deb_q) begin
                    state_d = (state_q == STABLE_LO) ? PEND_HI : PEND_LO;
                    dcnt_d  = CNT_W'(1);
                end
            end
            PEND_HI, PEND_LO: begin
                if (s2_q == deb_q) begin
                    state_d = (state_q == PEND_HI) ? STABLE_LO : STABLE_HI;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = (state_q == PEND_HI) ? STABLE_HI : STABLE_LO;
                    deb_d   = ~deb_q;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                dcnt_d  = '0;
                deb_d   = 1'b0;
            end
        endcase
    end

    // FSM state, run counter and the registered debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            dcnt_q  <= '0;
            deb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            deb_q   <= deb_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for the traffic-light controller: debounced sensors,
// a one-cycle TICK enable per controller step, and per-window sticky flags.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = TICK_CYCLES_5S,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int          CNT_W           = 32
) (
    input  logic CLK_100M,
    input  logic R,
    input  logic T_A_RAW,
    input  logic T_B_RAW,
    output logic TICK,
    output logic T_A,
    output logic T_B
);

    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic             deb_a, deb_b;
    logic [1:0]       deb_v;
    logic             wrap;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tick_q, tick_d;
    logic [1:0]       stk_q, stk_d;
    logic [1:0]       t_q, t_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
        .clk(CLK_100M), .rst_n(R), .raw(T_A_RAW), .deb(deb_a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clk(CLK_100M), .rst_n(R), .raw(T_B_RAW), .deb(deb_b)
    );

    assign deb_v = {deb_b, deb_a};

    // Step counter and window capture; a deb change on the wrap edge itself
    // is not seen here (pre-edge value) and lands in the next window.
    always_comb begin
        wrap   = (tcnt_q == TCNT_LAST);
        tcnt_d = wrap ? '0 : tcnt_q + CNT_W'(1);
        tick_d = wrap;
        t_d    = t_q;
        stk_d  = stk_q | deb_v;
        if (wrap) begin
            t_d   = stk_q | deb_v;
            stk_d = '0;
        end
    end

    // Counter, tick pulse, sticky bits and the held window flags.
    always_ff @(posedge CLK_100M or negedge R) begin
        if (!R) begin
            tcnt_q <= '0;
            tick_q <= 1'b0;
            stk_q  <= '0;
            t_q    <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            tick_q <= tick_d;
            stk_q  <= stk_d;
            t_q    <= t_d;
        end
    end

    assign TICK = tick_q;
    assign T_A  = t_q[0];
    assign T_B  = t_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench: a sample-history model predicts window flags at each wrap,
// the DUT's TICK pops and compares them; directed checks pin key scenarios.
module tb_traffic_sensor_conditioner;

    localparam int TC = 20;
    localparam int DC = 4;

    logic clk   = 1'b0;
    logic r_n   = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic tick, ta, tb;

    always #5 clk = ~clk;

    traffic_sensor_conditioner #(
        .TICK_CYCLES(TC), .DEBOUNCE_CYCLES(DC), .CNT_W(32)
    ) dut (
        .CLK_100M(clk), .R(r_n), .T_A_RAW(a_raw), .T_B_RAW(b_raw),
        .TICK(tick), .T_A(ta), .T_B(tb)
    );

    int total = 0;
    int bad   = 0;

    // Model state (bit 0 = street A, bit 1 = street B)
    logic [1:0] m_s1, m_s2, m_deb, m_stk, m_t;
    int         m_run[2];
    int         edge_n;
    int         probe_e;
    logic [1:0] sb_q[$];
    logic [1:0] tick_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_stk = '0; m_t = '0;
        m_run[0] = 0; m_run[1] = 0;
        edge_n = 0;
        sb_q.delete();
    endtask

    // Advance the model by one rising edge; raw is the value present before it.
    task automatic model_edge(input logic [1:0] raw);
        logic [1:0] deb_pre;
        deb_pre = m_deb;
        edge_n++;
        if (edge_n % TC == 0) begin
            m_t = m_stk | deb_pre;
            sb_q.push_back(m_t);
            m_stk = '0;
        end else begin
            m_stk = m_stk | deb_pre;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != deb_pre[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_deb[i] = ~deb_pre[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic ra, input logic rb);
        logic [1:0] e;
        a_raw = ra;
        b_raw = rb;
        @(posedge clk);
        model_edge({rb, ra});
        #1;
        chk("tick", tick, 32'((edge_n % TC) == 0));
        if (tick) begin
            if (sb_q.size() == 0) begin
                chk("tick_unexpected", tick, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("tick_t_a", ta, e[0]);
                chk("tick_t_b", tb, e[1]);
            end
            tick_log.push_back({tb, ta});
        end else begin
            chk("hold_t_a", ta, m_t[0]);
            chk("hold_t_b", tb, m_t[1]);
        end
        if (probe_e != 0 && edge_n == probe_e - 1) chk("deb_a_early", dut.u_deb_a.deb, 1'b0);
        if (probe_e != 0 && edge_n == probe_e)     chk("deb_a_rise",  dut.u_deb_a.deb, 1'b1);
        @(negedge clk);
    endtask

    // Called just after a falling edge; releases R on a falling edge.
    task automatic do_reset();
        r_n   = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        #1;
        chk("rst_tick", tick, 1'b0);
        chk("rst_t_a", ta, 1'b0);
        chk("rst_t_b", tb, 1'b0);
        repeat (3) @(negedge clk);
        r_n = 1'b1;
        model_reset();
        tick_log.delete();
    endtask

    // Raw sensor high before edges lo..hi inclusive (edges counted from release).
    task automatic run(input int n, input int a_lo, input int a_hi, input int b_lo, input int b_hi);
        for (int e = 1; e <= n; e++)
            step(e >= a_lo && e <= a_hi, e >= b_lo && e <= b_hi);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [1:0] exp);
        if (idx < tick_log.size()) chk(tag, tick_log[idx], exp);
        else                       chk({tag, "_count"}, tick_log.size(), idx + 1);
    endtask

    initial begin
        probe_e = 0;
        model_reset();
        @(negedge clk);

        // Idle: ticks at 20, 40, 60 with flags low
        do_reset();
        run(65, 0, 0, 0, 0);
        chk("idle_ticks", tick_log.size(), 3);
        chk_log("idle_w0", 0, 2'b00);
        chk_log("idle_w2", 2, 2'b00);

        // A held high: deb_a rises at edge 6, reported at the first tick
        do_reset();
        probe_e = 6;
        run(45, 1, 1000, 0, 0);
        probe_e = 0;
        chk_log("a_hold_w0", 0, 2'b01);
        chk_log("a_hold_w1", 1, 2'b01);

        // A bounce of 3 cycles is rejected
        do_reset();
        run(45, 1, 3, 0, 0);
        chk_log("bounce_w0", 0, 2'b00);
        chk_log("bounce_w1", 1, 2'b00);

        // B high within the first window only
        do_reset();
        run(45, 0, 0, 2, 9);
        chk_log("b_win_w0", 0, 2'b10);
        chk_log("b_win_w1", 1, 2'b00);

        // deb_b rises exactly on the wrap edge 20: belongs to the next window
        do_reset();
        run(45, 0, 0, 15, 1000);
        chk_log("b_wrap_w0", 0, 2'b00);
        chk_log("b_wrap_w1", 1, 2'b10);

        // Reset mid-window with T_A high: clears at once, next tick 20 edges later
        do_reset();
        run(30, 1, 1000, 0, 0);
        chk("pre_rst_t_a", ta, 1'b1);
        do_reset();
        run(25, 0, 0, 0, 0);
        chk("post_rst_ticks", tick_log.size(), 1);
        chk_log("post_rst_w0", 0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
